regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_rr_select.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// ---- regfile_write_arbiter_pkg : shared FSM states and register-select constants (rev 1.0) ----
`default_nettype none

package regfile_write_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [4:0] NO_WRITE  = 5'b10000;
  localparam int         REG_IDX_W = 4;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_select.sv
// ---- rr_select : combinational round-robin priority selector (rev 1.0) ----
`default_nettype none

module rr_select #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_oh,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  logic [PTR_W:0] cand;

  // Walk from ptr upward with wrap-around; the first requester found wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid                       = 1'b1;
        grant_idx                   = cand[PTR_W-1:0];
        grant_oh[cand[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ---- regfile_write_arbiter : round-robin register-file write arbiter with write protection (rev 1.0) ----
`default_nettype none

module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int          NREQ         = 4,
  parameter int          DATA_W       = 16,
  parameter logic [15:0] PROTECT_MASK = 16'h0001
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*REG_IDX_W-1:0]   dest,
  input  logic [NREQ*DATA_W-1:0]      data,
  output logic [4:0]                  reg_sel,
  output logic [DATA_W-1:0]           wr_data,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             ack,
  output logic [NREQ-1:0]             err,
  output logic                        busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_next;
  logic [NREQ-1:0]        win_oh;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_valid;
  logic [REG_IDX_W-1:0]   win_dest;
  logic [DATA_W-1:0]      win_data;

  rr_select #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req       (req),
    .ptr       (ptr),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  assign win_dest = dest[win_idx*REG_IDX_W +: REG_IDX_W];
  assign win_data = data[win_idx*DATA_W +: DATA_W];
  assign ptr_next = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;

  // The winning dest/data are captured straight into the output registers,
  // so the WRITE cycle presents them with no further staging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      reg_sel <= NO_WRITE;
      wr_data <= '0;
      gnt     <= '0;
      ack     <= '0;
      err     <= '0;
      busy    <= 1'b0;
    end else begin
      reg_sel <= NO_WRITE;
      gnt     <= '0;
      ack     <= '0;
      err     <= '0;
      busy    <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            ptr <= ptr_next;
            if (PROTECT_MASK[win_dest]) begin
              err <= win_oh;
            end else begin
              state   <= WRITE;
              reg_sel <= {1'b0, win_dest};
              wr_data <= win_data;
              gnt     <= win_oh;
              ack     <= win_oh;
              busy    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ---- tb_regfile_write_arbiter : self-checking bench for regfile_write_arbiter (rev 1.0) ----
`default_nettype none

module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] dest;
  logic [63:0] data;
  logic [4:0]  reg_sel;
  logic [15:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  req;
    int          idx;
    logic [3:0]  d;
    logic [15:0] v;
    logic [4:0]  exp_sel;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  d;
    logic [15:0] v;
  } sb_t;

  vec_t        vecs[5];
  sb_t         q[$];
  logic [3:0]  lane_d[4];
  logic [15:0] lane_v[4];
  logic [15:0] last_wd;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NREQ         (4),
    .DATA_W       (16),
    .PROTECT_MASK (16'h0001)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .dest    (dest),
    .data    (data),
    .reg_sel (reg_sel),
    .wr_data (wr_data),
    .gnt     (gnt),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic raise(input int i, input logic [3:0] d, input logic [15:0] v);
    dest[i*4 +: 4]   = d;
    data[i*16 +: 16] = v;
    req[i]           = 1'b1;
    q.push_back('{i, d, v});
  endtask

  // Requesters drop req the cycle after their ack and, while budget lasts,
  // raise it again one cycle later with fresh data.
  task automatic sb_run(input int max_cyc, input int spacing, input int gap_max, input int budget);
    int         cyc;
    int         last_any;
    int         last[4];
    logic [3:0] rr_pend;
    logic [3:0] rr_due;
    sb_t        e;
    cyc      = 0;
    last_any = -1;
    for (int i = 0; i < 4; i++) last[i] = -1;
    rr_pend = '0;
    rr_due  = '0;
    while ((q.size() != 0 || req != 0 || ((rr_pend | rr_due) != 0 && budget > 0)) && cyc < max_cyc) begin
      for (int i = 0; i < 4; i++) begin
        if (rr_due[i] && budget > 0) begin
          budget--;
          lane_v[i] = lane_v[i] + 16'h0101;
          raise(i, lane_d[i], lane_v[i]);
        end
      end
      rr_due  = rr_pend;
      rr_pend = '0;
      tick();
      cyc++;
      check("sb_exclusive",
            {31'd0, $onehot0(gnt) && $onehot0(ack) && $onehot0(err) && gnt == ack && !(ack != 0 && err != 0)},
            32'd1);
      if (err != 0) check("sb_err", {28'd0, err}, 32'd0);
      if (ack != 0) begin
        if (q.size() == 0) begin
          check("sb_unexpected_ack", {28'd0, ack}, 32'd0);
        end else begin
          e = q.pop_front();
          check("sb_ack", {28'd0, ack}, 32'(1 << e.idx));
          check("sb_sel", {27'd0, reg_sel}, {27'd0, 1'b0, e.d});
          check("sb_data", {16'd0, wr_data}, {16'd0, e.v});
          if (spacing > 0 && last_any >= 0) check("sb_spacing", cyc - last_any, spacing);
          if (gap_max > 0 && last[e.idx] >= 0) check("sb_gap_ok", {31'd0, (cyc - last[e.idx]) <= gap_max}, 32'd1);
          last_any    = cyc;
          last[e.idx] = cyc;
        end
        req     = req & ~ack;
        rr_pend = ack;
      end
    end
    if (cyc >= max_cyc) check("sb_timeout", cyc, 32'd0);
    check("sb_drained", q.size(), 32'd0);
    req = '0;
    q.delete();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    dest    = '0;
    data    = '0;
    vecs[0] = '{4'b0100, 2, 4'h5, 16'hBEEF, 5'b00101, 1'b0};
    vecs[1] = '{4'b0001, 0, 4'hF, 16'h1234, 5'b01111, 1'b0};
    vecs[2] = '{4'b1000, 3, 4'h0, 16'h0BAD, 5'b10000, 1'b1};
    vecs[3] = '{4'b0010, 1, 4'hA, 16'h5A5A, 5'b01010, 1'b0};
    vecs[4] = '{4'b0010, 1, 4'h0, 16'hDEAD, 5'b10000, 1'b1};

    // Reset values while reset_n is still low.
    tick();
    tick();
    check("rst_reg_sel", {27'd0, reg_sel}, 32'h10);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_err", {28'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    last_wd = 16'h0000;

    // Single-request vectors, including protected destinations.
    for (int n = 0; n < 5; n++) begin
      dest = 16'($urandom);
      data = {$urandom, $urandom};
      dest[vecs[n].idx*4 +: 4]   = vecs[n].d;
      data[vecs[n].idx*16 +: 16] = vecs[n].v;
      req  = vecs[n].req;
      tick();
      check("vec_reg_sel", {27'd0, reg_sel}, {27'd0, vecs[n].exp_sel});
      if (!vecs[n].exp_err) begin
        check("vec_wr_data", {16'd0, wr_data}, {16'd0, vecs[n].v});
        check("vec_gnt", {28'd0, gnt}, {28'd0, vecs[n].req});
        check("vec_ack", {28'd0, ack}, {28'd0, vecs[n].req});
        check("vec_err0", {28'd0, err}, 32'd0);
        check("vec_busy", {31'd0, busy}, 32'd1);
        last_wd = vecs[n].v;
      end else begin
        check("vec_err", {28'd0, err}, {28'd0, vecs[n].req});
        check("vec_noack", {28'd0, ack | gnt}, 32'd0);
        check("vec_busy0", {31'd0, busy}, 32'd0);
      end
      req = '0;
      tick();
      check("vec_after", {19'd0, reg_sel, gnt, ack, err, busy}, {19'd0, NO_WRITE, 4'd0, 4'd0, 4'd0, 1'b0});
      check("vec_wd_hold", {16'd0, wr_data}, {16'd0, last_wd});
    end

    // Pointer sits at 2 after the err on requester 1: 0 beats 1.
    dest[3:0]   = 4'h3;  data[15:0]  = 16'h1111;
    dest[7:4]   = 4'h7;  data[31:16] = 16'h2222;
    req = 4'b0011;
    tick();
    check("ptr_gnt0", {28'd0, gnt}, 32'b0001);
    check("ptr_sel0", {27'd0, reg_sel}, 32'b00011);
    req = 4'b0010;
    tick();
    check("ptr_gap", {28'd0, ack}, 32'd0);
    tick();
    check("ptr_gnt1", {28'd0, gnt}, 32'b0010);
    check("ptr_data1", {16'd0, wr_data}, 32'h2222);
    req = '0;
    tick();

    // All four requesters from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = 4'(i + 1);
      lane_v[i] = 16'(16'hA000 + i);
      raise(i, lane_d[i], lane_v[i]);
    end
    sb_run(40, 2, 0, 0);

    // Fairness between requesters 0 and 3 with re-raised requests.
    do_reset();
    lane_d[0] = 4'h9;  lane_v[0] = 16'h9000;
    lane_d[3] = 4'hC;  lane_v[3] = 16'hC000;
    raise(0, lane_d[0], lane_v[0]);
    raise(3, lane_d[3], lane_v[3]);
    sb_run(60, 2, 4, 4);

    // Reset during WRITE, then re-arbitration from requester 0.
    do_reset();
    dest[11:8]  = 4'h6;  data[47:32] = 16'h6666;
    dest[15:12] = 4'h8;  data[63:48] = 16'h8888;
    req = 4'b0100;
    tick();
    check("mw_sel", {27'd0, reg_sel}, 32'b00110);
    check("mw_ack", {28'd0, ack}, 32'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    check("mw_abort", {19'd0, reg_sel, gnt, ack, err, busy}, {19'd0, NO_WRITE, 4'd0, 4'd0, 4'd0, 1'b0});
    check("mw_wd_clr", {16'd0, wr_data}, 32'd0);
    req = 4'b1100;
    tick();
    check("mw_hold_ack", {28'd0, ack}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("mw_regrant", {28'd0, ack}, 32'b0100);
    check("mw_regrant_sel", {27'd0, reg_sel}, 32'b00110);
    check("mw_regrant_wd", {16'd0, wr_data}, 32'h6666);
    req = '0;
    tick();

    // Idle: no requests for 20 cycles.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle", {19'd0, reg_sel, gnt, ack, err, busy}, {19'd0, NO_WRITE, 4'd0, 4'd0, 4'd0, 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
